// File: rtl/sys_bridge_timer_pkg.sv
// Shared constants and types for the CPU-side system bridge and its two timer/counters.
package sys_bridge_timer_pkg;

  localparam logic [1:0] TC_IDLE = 2'b00;
  localparam logic [1:0] TC_LOAD = 2'b01;
  localparam logic [1:0] TC_CNT  = 2'b10;
  localparam logic [1:0] TC_INT  = 2'b11;

  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_RELOAD  = 2'b01;

  localparam logic [1:0] TC_REG_CTRL   = 2'd0;
  localparam logic [1:0] TC_REG_PRESET = 2'd1;
  localparam logic [1:0] TC_REG_COUNT  = 2'd2;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  // Only the auto-reload code re-arms; every other MODE value runs once.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == TC_MODE_RELOAD;
  endfunction

endpackage

// File: rtl/sys_bridge_timer_timer_counter.sv
// One memory-mapped timer/counter: CTRL/PRESET/COUNT registers, count FSM and masked IRQ.
module sys_bridge_timer_timer_counter
  import sys_bridge_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [3:2]  Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic [1:0]  o_state
);

  tc_ctrl_t    r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq;
  logic [1:0]  r_state;
  logic        w_ctrl_wr;

  assign w_ctrl_wr = WE && (Addr == TC_REG_CTRL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
      r_state  <= TC_IDLE;
    end else begin
      if (WE && (Addr == TC_REG_PRESET)) r_preset <= Din;
      if (w_ctrl_wr) begin
        r_ctrl <= tc_ctrl_t'(Din[3:0]);
        r_irq  <= 1'b0;
      end
      // A CTRL write with EN=0 overrides whatever the FSM would have done.
      if (w_ctrl_wr && !Din[0]) begin
        r_state <= TC_IDLE;
      end else begin
        case (r_state)
          TC_IDLE: if (r_ctrl.en) r_state <= TC_LOAD;
          TC_LOAD: begin
            r_count <= r_preset;
            r_state <= TC_CNT;
          end
          TC_CNT: begin
            if (!r_ctrl.en) begin
              r_state <= TC_IDLE;
            end else if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= '0;
              r_irq   <= 1'b1;
              r_state <= TC_INT;
            end
          end
          default: begin
            if (is_reload(r_ctrl.mode)) begin
              r_irq   <= 1'b0;
              r_state <= TC_LOAD;
            end else begin
              if (!w_ctrl_wr) r_ctrl.en <= 1'b0;
              r_state <= TC_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr)
      TC_REG_CTRL:   Dout = {28'b0, r_ctrl};
      TC_REG_PRESET: Dout = r_preset;
      TC_REG_COUNT:  Dout = r_count;
      default:       Dout = '0;
    endcase
  end

  assign IRQ     = r_irq & r_ctrl.im;
  assign o_state = r_state;

endmodule

// File: rtl/sys_bridge_timer.sv
// CPU bus bridge: decodes the two timer windows, muxes read data and builds the HWInt vector.
module sys_bridge_timer
  import sys_bridge_timer_pkg::*;
#(
  parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
  parameter int          SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] PrAddr,
  input  logic        PrWE,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  input  logic [3:0]  ExtInt,
  output logic [5:0]  HWInt,
  output logic [1:0]  o_tc0_state,
  output logic [1:0]  o_tc1_state
);

  logic        w_sel0;
  logic        w_sel1;
  logic [31:0] w_dout0;
  logic [31:0] w_dout1;
  logic        w_irq0;
  logic        w_irq1;
  logic [3:0]  r_sync [SYNC_STG];

  assign w_sel0 = (PrAddr[31:4] == TC0_BASE[31:4]);
  assign w_sel1 = (PrAddr[31:4] == TC1_BASE[31:4]);

  sys_bridge_timer_timer_counter u_tc0 (
    .clk     (clk),
    .reset   (reset),
    .WE      (PrWE && w_sel0),
    .Addr    (PrAddr[3:2]),
    .Din     (PrWD),
    .Dout    (w_dout0),
    .IRQ     (w_irq0),
    .o_state (o_tc0_state)
  );

  sys_bridge_timer_timer_counter u_tc1 (
    .clk     (clk),
    .reset   (reset),
    .WE      (PrWE && w_sel1),
    .Addr    (PrAddr[3:2]),
    .Din     (PrWD),
    .Dout    (w_dout1),
    .IRQ     (w_irq1),
    .o_state (o_tc1_state)
  );

  always_comb begin
    PrRD = '0;
    if (w_sel0)      PrRD = w_dout0;
    else if (w_sel1) PrRD = w_dout1;
  end

  // ExtInt is asynchronous to clk; only the last stage is allowed to reach HWInt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STG; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ExtInt;
      for (int i = 1; i < SYNC_STG; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign HWInt = {r_sync[SYNC_STG-1], w_irq1, w_irq0};

endmodule

// File: tb/tb_sys_bridge_timer.sv
// Self-checking bench for sys_bridge_timer against an arithmetic model of the timer behaviour.
module tb_sys_bridge_timer;
  import sys_bridge_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] PrAddr;
  logic        PrWE;
  logic [31:0] PrWD;
  logic [31:0] PrRD;
  logic [3:0]  ExtInt;
  logic [5:0]  HWInt;
  logic [1:0]  tc0_state;
  logic [1:0]  tc1_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sys_bridge_timer dut (
    .clk         (clk),
    .reset       (reset),
    .PrAddr      (PrAddr),
    .PrWE        (PrWE),
    .PrWD        (PrWD),
    .PrRD        (PrRD),
    .ExtInt      (ExtInt),
    .HWInt       (HWInt),
    .o_tc0_state (tc0_state),
    .o_tc1_state (tc1_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    PrAddr = a[31:2];
    PrWD   = d;
    PrWE   = 1'b1;
    @(posedge clk);
    #1;
    PrWE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    PrAddr = a[31:2];
    #1;
    d = PrRD;
  endtask

  // Expected timer view t edges after the enabling CTRL write (valid for t >= 2).
  function automatic void tc_model(input int p, input bit reload, input int t,
                                   output int cnt, output bit irq, output bit en);
    int pp;
    int per;
    int k;
    pp = (p == 0) ? 1 : p;
    if (!reload) begin
      cnt = (t - 2 >= p) ? 0 : p - (t - 2);
      irq = (t >= pp + 2);
      en  = (t < pp + 3);
    end else begin
      per = pp + 2;
      k   = (t - 2) % per;
      cnt = (k > pp || k >= p) ? 0 : p - k;
      irq = (k == pp);
      en  = 1'b1;
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    logic        seen;
    n_checks++;
    if (HWInt !== 6'b0) $display("FAIL reset_hwint: got %b expected 000000", HWInt);
    else n_pass++;
    rd(32'h7F00, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_ctrl0: got %h expected 0", d);
    else n_pass++;
    rd(32'h7F18, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_count1: got %h expected 0", d);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;

    wr(32'h7F04, 32'd10);
    wr(32'h7F00, 32'h9);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    rd(32'h7F08, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_midrun_count: got %h expected 0", d);
    else n_pass++;
    n_checks++;
    if (HWInt !== 6'b0 || tc0_state !== TC_IDLE)
      $display("FAIL reset_midrun_state: got hwint=%b state=%0d expected 0/0", HWInt, tc0_state);
    else n_pass++;
    rd(32'h7F04, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_midrun_preset: got %h expected 0", d);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= HWInt[0];
    end
    n_checks++;
    if (seen !== 1'b0 || tc0_state !== TC_IDLE)
      $display("FAIL reset_no_irq_after: got irq_seen=%b state=%0d expected 0/0", seen, tc0_state);
    else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(32'h7F04, 32'd3);
    wr(32'h7F00, 32'h9);
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (HWInt[0] !== (t >= 5)) $display("FAIL oneshot_irq t=%0d: got %b expected %b", t, HWInt[0], (t >= 5));
      else n_pass++;
      if (t >= 2) begin
        rd(32'h7F08, d);
        n_checks++;
        if (d !== ((t <= 5) ? 32'(5 - t) : 32'd0))
          $display("FAIL oneshot_count t=%0d: got %0d expected %0d", t, d, (t <= 5) ? 5 - t : 0);
        else n_pass++;
      end
    end
    wr(32'h7F00, 32'h0);
    n_checks++;
    if (HWInt[0] !== 1'b0) $display("FAIL oneshot_clear: got %b expected 0", HWInt[0]);
    else n_pass++;
  endtask

  task automatic test_reload();
    int cnt;
    bit irq;
    bit en;
    int pulses;
    pulses = 0;
    wr(32'h7F14, 32'd2);
    wr(32'h7F10, 32'hB);
    for (int t = 1; t <= 22; t++) begin
      @(posedge clk);
      #1;
      if (t >= 2) tc_model(2, 1'b1, t, cnt, irq, en);
      else irq = 1'b0;
      pulses += int'(HWInt[1]);
      n_checks++;
      if (HWInt[1] !== irq) $display("FAIL reload_irq t=%0d: got %b expected %b", t, HWInt[1], irq);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 5) $display("FAIL reload_pulse_count: got %0d expected 5", pulses);
    else n_pass++;
    wr(32'h7F10, 32'h0);
  endtask

  task automatic test_mask();
    logic [31:0] d;
    logic        seen;
    logic        hit_int;
    seen = 1'b0;
    hit_int = 1'b0;
    wr(32'h7F04, 32'd2);
    wr(32'h7F00, 32'h1);
    repeat (8) begin
      @(posedge clk);
      #1;
      seen |= HWInt[0];
      hit_int |= (tc0_state == TC_INT);
    end
    n_checks++;
    if (seen !== 1'b0 || hit_int !== 1'b1)
      $display("FAIL mask_irq: got irq_seen=%b int_reached=%b expected 0/1", seen, hit_int);
    else n_pass++;
    rd(32'h7F00, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL mask_ctrl_en_cleared: got %h expected 0", d);
    else n_pass++;
    rd(32'h7F08, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL mask_count: got %h expected 0", d);
    else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [31:0] v;
    logic [31:0] a;
    v = $urandom;
    wr(32'h7F08, v);
    rd(32'h7F08, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL decode_count_ro: got %h expected 0", d);
    else n_pass++;
    rd(32'h7F0C, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL decode_7f0c: got %h expected 0", d);
    else n_pass++;
    rd(32'h7F20, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL decode_7f20: got %h expected 0", d);
    else n_pass++;
    v = $urandom;
    wr(32'h7F14, v);
    rd(32'h7F14, d);
    n_checks++;
    if (d !== v) $display("FAIL decode_preset1: got %h expected %h", d, v);
    else n_pass++;
    rd(32'h7F04, d);
    n_checks++;
    if (d !== 32'd2) $display("FAIL decode_preset0_kept: got %h expected 2", d);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      a = 32'h8000 + 32'($urandom_range(0, 255) << 2);
      rd(a, d);
      n_checks++;
      if (d !== 32'h0) $display("FAIL decode_unmapped %h: got %h expected 0", a, d);
      else n_pass++;
    end
  endtask

  task automatic test_int_write();
    logic [31:0] d;
    int cnt;
    bit irq;
    bit en;
    wr(32'h7F04, 32'd1);
    wr(32'h7F00, 32'h9);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tc0_state !== TC_INT || HWInt[0] !== 1'b1)
      $display("FAIL intwr_in_int: got state=%0d irq=%b expected 3/1", tc0_state, HWInt[0]);
    else n_pass++;
    wr(32'h7F00, 32'h9);
    rd(32'h7F00, d);
    n_checks++;
    if (d !== 32'h9) $display("FAIL intwr_en_kept: got %h expected 9", d);
    else n_pass++;
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk);
      #1;
      if (t >= 2) begin
        tc_model(1, 1'b0, t, cnt, irq, en);
        n_checks++;
        if (HWInt[0] !== irq) $display("FAIL intwr_rerun t=%0d: got %b expected %b", t, HWInt[0], irq);
        else n_pass++;
      end
    end
    wr(32'h7F00, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] base;
    logic [3:0]  cv;
    int tc;
    int p;
    int cnt;
    bit reload;
    bit im;
    bit irq;
    bit en;
    for (int trial = 0; trial < 8; trial++) begin
      tc     = $urandom_range(0, 1);
      p      = $urandom_range(0, 5);
      reload = 1'($urandom_range(0, 1));
      im     = 1'($urandom_range(0, 1));
      base   = (tc == 0) ? 32'h7F00 : 32'h7F10;
      cv     = {im, 1'b0, reload, 1'b1};
      wr(base, 32'h0);
      wr(base + 32'h4, 32'(p));
      wr(base, {28'b0, cv});
      for (int t = 1; t <= 14; t++) begin
        @(posedge clk);
        #1;
        if (t >= 2) begin
          tc_model(p, reload, t, cnt, irq, en);
          n_checks++;
          if (HWInt[tc] !== (irq & im))
            $display("FAIL rand_irq tc=%0d p=%0d rl=%0d t=%0d: got %b expected %b", tc, p, reload, t, HWInt[tc], irq & im);
          else n_pass++;
          rd(base + 32'h8, d);
          n_checks++;
          if (d !== 32'(cnt))
            $display("FAIL rand_count tc=%0d p=%0d rl=%0d t=%0d: got %0d expected %0d", tc, p, reload, t, d, cnt);
          else n_pass++;
          rd(base, d);
          n_checks++;
          if (d !== {28'b0, cv[3:1], en})
            $display("FAIL rand_ctrl tc=%0d p=%0d rl=%0d t=%0d: got %h expected %h", tc, p, reload, t, d, {cv[3:1], en});
          else n_pass++;
        end
      end
      wr(base, 32'h0);
    end
  endtask

  task automatic test_extint();
    logic [3:0] exp_q[$];
    logic [3:0] v;
    logic [3:0] e;
    ExtInt = 4'h0;
    repeat (3) @(posedge clk);
    #3;
    ExtInt = 4'b0100;
    @(posedge clk);
    #1;
    n_checks++;
    if (HWInt[4] !== 1'b0) $display("FAIL extint_edge1: got %b expected 0", HWInt[4]);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (HWInt[4] !== 1'b1) $display("FAIL extint_edge2: got %b expected 1", HWInt[4]);
    else n_pass++;
    ExtInt = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(4'h0);
    for (int i = 0; i < 24; i++) begin
      v = 4'($urandom);
      ExtInt = v;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (HWInt[5:2] !== e) $display("FAIL extint_rand i=%0d: got %b expected %b", i, HWInt[5:2], e);
      else n_pass++;
    end
    ExtInt = 4'h0;
  endtask

  initial begin
    reset  = 1'b0;
    PrAddr = '0;
    PrWE   = 1'b0;
    PrWD   = '0;
    ExtInt = 4'h0;
    #1;
    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_decode();
    test_int_write();
    test_random();
    test_extint();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
